// File: rtl/mem_stage_pkg.sv
// Shared opcode and FSM definitions for the memory-access stage.
// Opcodes outside the listed set are treated as NOP by every helper here.
package mem_stage_pkg;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: is_load = 1'b1;
            default:                                  is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
            default:                is_store = 1'b0;
        endcase
    endfunction

    // Index of the final byte of the transfer (N-1).
    function automatic logic [1:0] last_idx(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: last_idx = 2'd0;
            MEM_LH, MEM_LHU, MEM_SH: last_idx = 2'd1;
            default:                 last_idx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of an assembled little-endian load value.
// Word loads and stores pass the latched value through unchanged.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] bytes_in,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = bytes_in;
        case (op)
            MEM_LB:  data_out = {{24{bytes_in[7]}}, bytes_in[7:0]};
            MEM_LBU: data_out = {24'd0, bytes_in[7:0]};
            MEM_LH:  data_out = {{16{bytes_in[15]}}, bytes_in[15:0]};
            MEM_LHU: data_out = {16'd0, bytes_in[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes non-memory ops through and runs loads/stores
// as byte-serial little-endian transfers over an 8-bit req/ack controller port.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REGA_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              ex_we,
    input  logic [REGA_W-1:0] ex_w_addr,
    input  logic [DATA_W-1:0] ex_w_data,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    output logic              mem_we,
    output logic [REGA_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              busy_out,
    output logic              mc_req,
    output logic              mc_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [7:0]        mc_dout,
    input  logic              mc_ack,
    input  logic [7:0]        mc_din
);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic [REGA_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] ext_data;
    logic              ex_is_mem;

    assign ex_is_mem = is_load(ex_mem_op) || is_store(ex_mem_op);

    mem_load_ext u_ext (
        .op       (op_q),
        .bytes_in (data_q),
        .data_out (ext_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        if (rdy_in) begin
            case (state_q)
                S_IDLE: if (ex_is_mem) begin
                    state_d = S_XFER;
                    cnt_d   = 2'd0;
                    op_d    = ex_mem_op;
                    addr_d  = ex_mem_addr;
                    data_d  = ex_w_data;
                    we_d    = ex_we;
                    waddr_d = ex_w_addr;
                end
                S_XFER: if (mc_ack) begin
                    // Load bytes overwrite the latched word in place; stores leave it intact.
                    if (is_load(op_q)) data_d[{cnt_q, 3'b000} +: 8] = mc_din;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == last_idx(op_q)) state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MEM_NOP;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
        end
    end

    // Outputs are held at zero while reset is asserted, even with live EX inputs.
    always_comb begin
        mem_we     = 1'b0;
        mem_w_addr = '0;
        mem_w_data = '0;
        busy_out   = 1'b0;
        mc_req     = 1'b0;
        mc_wr      = 1'b0;
        mc_addr    = '0;
        mc_dout    = '0;
        if (rst_in) begin
            case (state_q)
                S_IDLE: begin
                    if (ex_is_mem) begin
                        busy_out = 1'b1;
                    end else begin
                        mem_we     = ex_we;
                        mem_w_addr = ex_w_addr;
                        mem_w_data = ex_w_data;
                    end
                end
                S_XFER: begin
                    busy_out = 1'b1;
                    mc_req   = rdy_in;
                    mc_wr    = is_store(op_q);
                    mc_addr  = addr_q + ADDR_W'(cnt_q);
                    mc_dout  = data_q[{cnt_q, 3'b000} +: 8];
                end
                S_DONE: begin
                    mem_we     = we_q;
                    mem_w_addr = waddr_q;
                    mem_w_data = ext_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a byte-addressed memory model answers the controller
// port, a per-cycle checker follows the expected byte stream, writebacks are predicted.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk_in, rst_in, rdy_in;
    logic        ex_we;
    logic [31:0] ex_w_addr, ex_w_data, ex_mem_addr;
    logic [3:0]  ex_mem_op;
    logic        mem_we, busy_out, mc_req, mc_wr, mc_ack;
    logic [31:0] mem_w_addr, mem_w_data, mc_addr;
    logic [7:0]  mc_dout, mc_din;

    mem_stage dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .ex_we(ex_we), .ex_w_addr(ex_w_addr), .ex_w_data(ex_w_data),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr),
        .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .busy_out(busy_out), .mc_req(mc_req), .mc_wr(mc_wr), .mc_addr(mc_addr),
        .mc_dout(mc_dout), .mc_ack(mc_ack), .mc_din(mc_din)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
    } xfer_t;

    xfer_t      exp_q[$];
    logic [7:0] mem [logic [31:0]];
    int         checks = 0;
    int         errors = 0;
    int         ack_delay = 0;
    int         dly_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic int nbytes(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic logic st_op(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Queue the expected byte transfers and predict the writeback value.
    task automatic plan(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] expv);
        logic [31:0] raw;
        raw = 0;
        for (int i = 0; i < nbytes(op); i++) begin
            exp_q.push_back('{a: addr + 32'(i), wr: st_op(op), d: wdata[8*i +: 8]});
            raw = raw | (32'(rd_mem(addr + 32'(i))) << (8 * i));
        end
        case (op)
            MEM_LB:  expv = 32'($signed(raw[7:0]));
            MEM_LH:  expv = 32'($signed(raw[15:0]));
            MEM_LBU, MEM_LHU, MEM_LW: expv = raw;
            default: expv = wdata;
        endcase
    endtask

    // Memory controller model plus per-cycle protocol checks; acks when mc_req is low are spurious.
    initial forever begin
        @(negedge clk_in);
        #1;
        mc_ack = mc_req ? (dly_cnt >= ack_delay) : 1'b1;
        mc_din = mc_req ? rd_mem(mc_addr) : 8'hEE;
        #1;
        if (rst_in) begin
            if (!rdy_in) chk("req_while_not_rdy", mc_req, 1'b0);
            if (busy_out) chk("we_while_busy", mem_we, 1'b0);
            if (mc_req) begin
                chk("busy_with_req", busy_out, 1'b1);
                if (exp_q.size() == 0) chk("unexpected_req", 1'b1, 1'b0);
                else begin
                    chk("mc_addr", mc_addr, exp_q[0].a);
                    chk("mc_wr", mc_wr, exp_q[0].wr);
                    if (exp_q[0].wr) chk("mc_dout", mc_dout, exp_q[0].d);
                end
            end
            if (mc_req && mc_ack) begin
                if (mc_wr) mem[mc_addr] = mc_dout;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                dly_cnt = 0;
            end else if (mc_req) begin
                dly_cnt++;
            end
        end
    end

    task automatic set_ex(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] waddr, input logic we);
        ex_mem_op = op; ex_mem_addr = addr; ex_w_data = wdata; ex_w_addr = waddr; ex_we = we;
    endtask

    // Issue one memory op at a falling edge; returns the DONE-cycle data and busy length.
    task automatic run_mem(input string name, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] waddr, input logic we,
                           input int dly, input int stall_at, input int stall_len,
                           output logic [31:0] got, output int busy_n);
        logic [31:0] expv;
        plan(op, addr, wdata, expv);
        ack_delay = dly;
        dly_cnt   = 0;
        set_ex(op, addr, wdata, waddr, we);
        busy_n = 0;
        #2;
        while (busy_out && busy_n < 100) begin
            busy_n++;
            @(negedge clk_in);
            set_ex(MEM_NOP, 0, 0, 0, 1'b0);
            rdy_in = !((busy_n + 1) >= stall_at && (busy_n + 1) < stall_at + stall_len);
            #2;
        end
        rdy_in = 1'b1;
        chk({name, "_busy_len"}, busy_n, 1 + nbytes(op) * (dly + 1) + stall_len);
        chk({name, "_we"}, mem_we, we);
        chk({name, "_waddr"}, mem_w_addr, waddr);
        chk({name, "_wdata"}, mem_w_data, expv);
        chk({name, "_bytes_left"}, exp_q.size(), 0);
        got = mem_w_data;
        @(negedge clk_in);
    endtask

    initial begin
        logic [31:0] got, expv;
        int          bn;
        rst_in = 1'b0; rdy_in = 1'b1;
        mc_ack = 1'b0; mc_din = 8'h00;
        set_ex(MEM_NOP, 32'h44, 32'h1234, 32'd5, 1'b1);
        #2;
        chk("rst_we", mem_we, 0);       chk("rst_waddr", mem_w_addr, 0);
        chk("rst_wdata", mem_w_data, 0); chk("rst_busy", busy_out, 0);
        chk("rst_req", mc_req, 0);      chk("rst_wr", mc_wr, 0);
        chk("rst_mcaddr", mc_addr, 0);  chk("rst_dout", mc_dout, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        set_ex(MEM_NOP, 0, 0, 0, 1'b0);
        @(negedge clk_in);

        // Pass-through, including an undefined opcode.
        set_ex(MEM_NOP, 32'h44, 32'h1234, 32'd5, 1'b1);
        #2;
        chk("nop_we", mem_we, 1); chk("nop_waddr", mem_w_addr, 5);
        chk("nop_wdata", mem_w_data, 32'h1234); chk("nop_busy", busy_out, 0);
        @(negedge clk_in);
        set_ex(4'hC, 32'h88, 32'hBEEF, 32'd9, 1'b1);
        #2;
        chk("undef_we", mem_we, 1); chk("undef_wdata", mem_w_data, 32'hBEEF);
        chk("undef_busy", busy_out, 0); chk("undef_req", mc_req, 0);
        @(negedge clk_in);
        set_ex(MEM_NOP, 0, 0, 0, 1'b0);
        @(negedge clk_in);

        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        run_mem("lw", MEM_LW, 32'h100, 0, 32'd3, 1'b1, 0, 0, 0, got, bn);
        chk("lw_lit", got, 32'h12345678); chk("lw_busy_lit", bn, 5);

        mem[32'h300] = 8'h80;
        run_mem("lb", MEM_LB, 32'h300, 0, 32'd4, 1'b1, 0, 0, 0, got, bn);
        chk("lb_lit", got, 32'hFFFFFF80);
        run_mem("lbu", MEM_LBU, 32'h300, 0, 32'd4, 1'b1, 0, 0, 0, got, bn);
        chk("lbu_lit", got, 32'h00000080);
        mem[32'h201] = 8'h00; mem[32'h202] = 8'h80;
        run_mem("lh", MEM_LH, 32'h201, 0, 32'd6, 1'b1, 1, 0, 0, got, bn);
        chk("lh_lit", got, 32'hFFFF8000);
        run_mem("lhu", MEM_LHU, 32'h201, 0, 32'd6, 1'b1, 0, 0, 0, got, bn);
        chk("lhu_lit", got, 32'h00008000);

        run_mem("sh", MEM_SH, 32'hFFFFFFFF, 32'hAABBCCDD, 32'd0, 1'b0, 3, 0, 0, got, bn);
        chk("sh_busy_lit", bn, 9);
        chk("sh_byte0", rd_mem(32'hFFFFFFFF), 8'hDD);
        chk("sh_byte1_wrap", rd_mem(32'h00000000), 8'hCC);

        run_mem("sb_stall", MEM_SB, 32'h400, 32'h0000005A, 32'd0, 1'b0, 0, 2, 2, got, bn);
        chk("sb_busy_lit", bn, 4);
        chk("sb_byte", rd_mem(32'h400), 8'h5A);

        // Back-to-back: store a word then read it back.
        run_mem("sw", MEM_SW, 32'h500, 32'hCAFEBABE, 32'd0, 1'b0, 0, 0, 0, got, bn);
        run_mem("lw_back", MEM_LW, 32'h500, 0, 32'd7, 1'b1, 2, 3, 1, got, bn);
        chk("lw_back_lit", got, 32'hCAFEBABE);

        // Reset while the third byte of a word load is outstanding.
        plan(MEM_LW, 32'h100, 0, expv);
        ack_delay = 0; dly_cnt = 0;
        set_ex(MEM_LW, 32'h100, 0, 32'd3, 1'b1);
        @(negedge clk_in); set_ex(MEM_NOP, 0, 0, 0, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in);
        #2;
        chk("rstx_cnt2_addr", mc_addr, 32'h102);
        #1;
        rst_in = 1'b0;
        set_ex(MEM_NOP, 0, 32'hDEAD, 32'd7, 1'b1);
        #1;
        chk("rstx_we", mem_we, 0); chk("rstx_wdata", mem_w_data, 0);
        chk("rstx_req", mc_req, 0); chk("rstx_busy", busy_out, 0);
        chk("rstx_mcaddr", mc_addr, 0);
        exp_q.delete();
        @(negedge clk_in);
        rst_in = 1'b1;
        set_ex(MEM_NOP, 0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("post_rst_we", mem_we, 0); chk("post_rst_busy", busy_out, 0);
            chk("post_rst_req", mc_req, 0); chk("post_rst_wdata", mem_w_data, 0);
            @(negedge clk_in);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the in-order pipeline, between the EX/MEM register and the MEM/WB register (`r_mem_wb`).
- Non-memory instructions pass straight through to the writeback fields.
- Loads and stores run as byte-serial, little-endian transfers over an 8-bit req/ack port to the memory controller.
- While a transfer is in progress, the stage asserts `busy_out`, which stalls upstream and drives `busy_in` of MEM/WB.

Parameters:
- ADDR_W, 32, width of the memory byte address.
- REGA_W, 32, width of the writeback register address; matches MEM/WB `w_addr`.
- DATA_W, 32, writeback and store data width; fixed at 32, parameter exists for checking only.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when low, the stage freezes.
- ex_we  input  1  writeback enable from EX/MEM.
- ex_w_addr  input  REGA_W  destination register.
- ex_w_data  input  DATA_W  ALU result; for stores, this is the store data.
- ex_mem_op  input  4  memory opcode (shared encoding).
- ex_mem_addr  input  ADDR_W  effective byte address.
- mem_we  output  1  writeback enable to MEM/WB.
- mem_w_addr  output  REGA_W  to MEM/WB.
- mem_w_data  output  DATA_W  to MEM/WB.
- busy_out  output  1  stall request to upstream and to MEM/WB `busy_in`.
- mc_req  output  1  byte request to the memory controller.
- mc_wr  output  1  1 = write, 0 = read.
- mc_addr  output  ADDR_W  byte address.
- mc_dout  output  8  write byte.
- mc_ack  input  1  request accepted; `mc_din` is valid in the same cycle.
- mc_din  input  8  read byte.

Behaviour:
- Reset (`rst_in` = 0, takes effect immediately):
  - FSM goes to IDLE, byte counter = 0, latched fields = 0.
  - `mc_req`, `mc_wr`, `mem_we` = 0; `mem_w_addr`, `mem_w_data`, `mc_addr`, `mc_dout` = 0; `busy_out` = 0.
  - Reset during XFER abandons the transfer; no partial writeback occurs.
- Opcodes: NOP, LB, LH, LW, LBU, LHU, SB, SH, SW.
  - Byte count N = 1 / 2 / 4 for B / H / W.
  - Undefined codes are treated as NOP.
- IDLE:
  - NOP: outputs are a combinational copy of `ex_we`, `ex_w_addr`, `ex_w_data`; `busy_out` = 0.
  - Memory op:
    - `busy_out` = 1 combinationally and `mem_we` = 0.
    - At the clock edge, latch op, address, store data, `we` and `w_addr`; set counter = 0; go to XFER.
- XFER:
  - Drives `mc_req` = 1, `mc_wr` = store, `mc_addr` = latched address + counter (modulo 2^ADDR_W; wrap is allowed), `mc_dout` = store byte[counter].
  - On `mc_ack`: a load captures `mc_din` into byte[counter] and the counter increments.
  - The ack of byte N-1 moves the FSM to DONE.
  - `busy_out` = 1 and `mem_we` = 0 throughout.
  - `mc_ack` may arrive in the same cycle the request is first driven.
  - No alignment requirement.
- DONE (exactly one cycle):
  - `busy_out` = 0; upstream advances at this edge.
  - `mem_we` = latched `we`; `mem_w_addr` = latched `w_addr`.
  - `mem_w_data`:
    - Loads: assembled value; LB/LH sign-extended, LBU/LHU zero-extended.
    - Stores: latched data.
  - Current EX inputs are ignored in DONE; the next state is IDLE.
- `rdy_in` = 0:
  - FSM, counter and latches hold.
  - `mc_req` is forced to 0, so the controller must not ack.
  - `busy_out` keeps its current value.
  - In IDLE, a memory op is not latched.
- Minimum latency with zero-wait ack: N+1 busy cycles, then DONE.
  - LW: busy for 5 cycles, result on the 6th.
- Back-to-back memory ops: the second op is seen in IDLE on the cycle after DONE.
- `mc_ack` while `mc_req` = 0 is ignored.

Decomposition:
- Shared package (defines.v):
  - opcode constants MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW.
  - FSM state constants S_IDLE, S_XFER, S_DONE.
- Sub-module `mem_load_ext`: combinational; takes op and assembled bytes and produces the extended 32-bit result.

Test Plan:
- Reset mid-XFER of LW (counter = 2), release → all outputs 0, IDLE, `mc_req` = 0, no `mem_we` pulse.
- NOP with `we` = 1, `w_addr` = 5, data = 0x1234 → same-cycle `mem_we` = 1, `w_addr` = 5, `w_data` = 0x1234, `busy_out` = 0.
- LW at 0x100 with zero-wait ack returning 0x78, 0x56, 0x34, 0x12:
  - `mc_addr` sequence 0x100 to 0x103.
  - `busy_out` high for 5 cycles.
  - DONE: `mem_w_data` = 0x12345678, `mem_we` = 1.
- LB returning 0x80 → 0xFFFFFF80; LBU returning 0x80 → 0x00000080; LH at 0x201 returning 0x00, 0x80 → 0xFFFF8000.
- SH data 0xAABBCCDD at 0xFFFFFFFF, ack delayed 3 cycles per byte → writes 0xDD at 0xFFFFFFFF and 0xCC at 0x00000000; `busy_out` low only in DONE; `mem_we` = 0.
- SB with `rdy_in` dropped for 2 cycles during XFER → `mc_req` = 0 for those cycles, state holds, transfer completes after resume.
